// File: rtl/feedback_div_pkg.sv
// Shared constants for the PLL feedback pulse-swallow counter.
// MIN_P keeps the divided clock toggling even when P is programmed to 0 or 1.
package feedback_div_pkg;
   localparam int P_WIDTH   = 6;
   localparam int S_WIDTH   = 5;
   localparam int DEFAULT_P = 32;
   localparam int DEFAULT_S = 0;
   localparam int MIN_P     = 2;
endpackage

// File: rtl/feedback_div_counter_if.sv
// Configuration and output bundle of the feedback divider counter.
// The counter block is the slave; the enclosing wrapper/bench is the master.
interface feedback_div_counter_if;
   import feedback_div_pkg::*;

   logic [P_WIDTH-1:0] divP;
   logic [S_WIDTH-1:0] divS;
   logic               skip;
   logic               clkDiv;
   logic               wrapPulse;

   modport master (output divP, divS, input skip, clkDiv, wrapPulse);
   modport slave  (input divP, divS, output skip, clkDiv, wrapPulse);
endinterface

// File: rtl/feedback_div_counter.sv
// Pulse-swallow counter behind the 2/3 prescaler: one output period spans
// 2*P + S fast-clock cycles. Single copy; triplication happens in the wrapper.
module feedback_div_counter (
   input logic                   clk1G28,
   input logic                   enable,
   feedback_div_counter_if.slave fb
);
   import feedback_div_pkg::*;

   function automatic logic [P_WIDTH-1:0] p_eff_of(input logic [P_WIDTH-1:0] p);
      return (p < P_WIDTH'(MIN_P)) ? P_WIDTH'(MIN_P) : p;
   endfunction

   function automatic logic [P_WIDTH-1:0] s_eff_of(input logic [S_WIDTH-1:0] s,
                                                   input logic [P_WIDTH-1:0] pe);
      return (P_WIDTH'(s) > pe) ? pe : P_WIDTH'(s);
   endfunction

   logic [P_WIDTH-1:0] cnt_reg, cnt_next;
   logic [P_WIDTH-1:0] shadow_p_reg, shadow_p_next;
   logic [S_WIDTH-1:0] shadow_s_reg, shadow_s_next;
   logic [P_WIDTH-1:0] p_eff, p_eff_next, s_eff_next;
   logic               skip_reg, skip_next;
   logic               clk_div_reg, clk_div_next;
   logic               wrap_reg, wrap_next;
   logic               at_end, upset;

   always_comb begin
      p_eff         = p_eff_of(shadow_p_reg);
      upset         = (cnt_reg >= p_eff);
      at_end        = (cnt_reg == p_eff - P_WIDTH'(1));
      cnt_next      = cnt_reg + P_WIDTH'(1);
      shadow_p_next = shadow_p_reg;
      shadow_s_next = shadow_s_reg;

      // An out-of-range count is only reachable through an upset; recover
      // immediately without reloading the configuration.
      if (upset) begin
         cnt_next = '0;
      end else if (at_end) begin
         cnt_next      = '0;
         shadow_p_next = fb.divP;
         shadow_s_next = fb.divS;
      end

      // Outputs are decoded from the state being entered so they are registered.
      p_eff_next   = p_eff_of(shadow_p_next);
      s_eff_next   = s_eff_of(shadow_s_next, p_eff_next);
      skip_next    = (cnt_next < s_eff_next);
      clk_div_next = (cnt_next < (p_eff_next >> 1));
      wrap_next    = upset || (cnt_next == p_eff_next - P_WIDTH'(1));
   end

   always_ff @(posedge clk1G28 or negedge enable) begin
      if (!enable) begin
         cnt_reg      <= '0;
         shadow_p_reg <= P_WIDTH'(DEFAULT_P);
         shadow_s_reg <= S_WIDTH'(DEFAULT_S);
         skip_reg     <= 1'b0;
         clk_div_reg  <= 1'b0;
         wrap_reg     <= 1'b0;
      end else begin
         cnt_reg      <= cnt_next;
         shadow_p_reg <= shadow_p_next;
         shadow_s_reg <= shadow_s_next;
         skip_reg     <= skip_next;
         clk_div_reg  <= clk_div_next;
         wrap_reg     <= wrap_next;
      end
   end

   assign fb.skip      = skip_reg;
   assign fb.clkDiv    = clk_div_reg;
   assign fb.wrapPulse = wrap_reg;
endmodule

// File: tb/tb_feedback_div_counter.sv
// Directed bench for feedback_div_counter: a period-position model checked
// every cycle, plus hand-computed period length / duty / swallow totals.
module tb_feedback_div_counter;
   import feedback_div_pkg::*;

   logic clk1G28 = 1'b0;
   logic enable  = 1'b0;
   always #5 clk1G28 = ~clk1G28;

   feedback_div_counter_if fb_if ();

   feedback_div_counter dut (
      .clk1G28 (clk1G28),
      .enable  (enable),
      .fb      (fb_if.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   // Period statistics gathered from the DUT outputs between wrap pulses.
   int wrap_count = 0;
   int cyc_acc = 0, hi_acc = 0, skip_acc = 0, tot_acc = 0;
   int last_period = 0, last_high = 0, last_skip = 0, last_total = 0;

   // Model: position within the period plus the configuration in force.
   int   m_pos = 0, m_p = DEFAULT_P, m_s = DEFAULT_S;
   logic m_skip = 1'b0, m_clk = 1'b0, m_wrap = 1'b0;
   int   upset_req = 0, upset_ack = 0;

   function automatic int peff_of(input int p);
      return (p < MIN_P) ? MIN_P : p;
   endfunction

   function automatic int seff_of(input int s, input int p);
      return (s > peff_of(p)) ? peff_of(p) : s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step();
      int  len;
      bit  forced;
      if (!enable) begin
         m_pos = 0; m_p = DEFAULT_P; m_s = DEFAULT_S;
         m_skip = 1'b0; m_clk = 1'b0; m_wrap = 1'b0;
      end else begin
         if (upset_req != upset_ack) begin
            m_pos     = 50;
            upset_ack = upset_req;
         end
         len    = peff_of(m_p);
         forced = (m_pos >= len);
         if (forced) begin
            m_pos = 0;
         end else if (m_pos == len - 1) begin
            m_pos = 0;
            m_p   = int'(fb_if.divP);
            m_s   = int'(fb_if.divS);
         end else begin
            m_pos++;
         end
         len    = peff_of(m_p);
         m_skip = (m_pos < seff_of(m_s, m_p));
         m_clk  = (m_pos < len / 2);
         m_wrap = forced || (m_pos == len - 1);
      end
   endtask

   task automatic compare_step();
      if (check_en && enable) begin
         check("skip", fb_if.skip, m_skip);
         check("clkDiv", fb_if.clkDiv, m_clk);
         check("wrapPulse", fb_if.wrapPulse, m_wrap);
         cyc_acc++;
         hi_acc   += (fb_if.clkDiv === 1'b1) ? 1 : 0;
         skip_acc += (fb_if.skip === 1'b1) ? 1 : 0;
         tot_acc  += (fb_if.skip === 1'b1) ? 3 : 2;
         if (fb_if.wrapPulse === 1'b1) begin
            last_period = cyc_acc; last_high = hi_acc;
            last_skip   = skip_acc; last_total = tot_acc;
            cyc_acc = 0; hi_acc = 0; skip_acc = 0; tot_acc = 0;
            wrap_count++;
         end
      end else begin
         cyc_acc = 0; hi_acc = 0; skip_acc = 0; tot_acc = 0;
      end
   endtask

   task automatic step();
      @(negedge clk1G28);
      #1;
   endtask

   task automatic wait_wrap(input int limit, output int waited);
      int start;
      start  = wrap_count;
      waited = 0;
      while (wrap_count == start && waited < limit) begin
         step();
         waited++;
      end
      if (wrap_count == start) begin
         vectors++;
         miscompares++;
         $display("FAIL wrap_timeout: no wrapPulse within %0d cycles", limit);
      end
   endtask

   task automatic check_period(input string tag, input int len, input int high,
                               input int skips, input int total);
      check({tag, "_period"}, last_period, len);
      check({tag, "_high"}, last_high, high);
      check({tag, "_skip"}, last_skip, skips);
      check({tag, "_total2G56"}, last_total, total);
   endtask

   initial begin
      int w;
      fork
         forever begin
            @(posedge clk1G28 or negedge enable);
            model_step();
         end
         forever begin
            @(negedge clk1G28);
            compare_step();
         end
      join_none

      // Reset defaults.
      fb_if.divP = 6'd32;
      fb_if.divS = 5'd0;
      check_en   = 1'b1;
      #32;
      check("rst_skip", fb_if.skip, 1'b0);
      check("rst_clkDiv", fb_if.clkDiv, 1'b0);
      check("rst_wrap", fb_if.wrapPulse, 1'b0);
      step();
      enable = 1'b1;
      wait_wrap(100, w);
      check("first_wrap_delay", w, 31);
      wait_wrap(100, w);
      check_period("default", 32, 16, 0, 64);

      // Swallow 14 of 25.
      fb_if.divP = 6'd25;
      fb_if.divS = 5'd14;
      wait_wrap(100, w);
      wait_wrap(100, w);
      check_period("swallow", 25, 12, 14, 64);

      // Mid-period reprogram 32 -> 20 at cnt=10.
      fb_if.divP = 6'd32;
      fb_if.divS = 5'd0;
      wait_wrap(100, w);
      wait_wrap(100, w);
      for (int i = 0; i < 11; i++) step();
      fb_if.divP = 6'd20;
      wait_wrap(100, w);
      check("reprog_old_wait", w, 21);
      check_period("reprog_old", 32, 16, 0, 64);
      wait_wrap(100, w);
      check_period("reprog_new", 20, 10, 0, 40);

      // Clamp: P=1 -> 2, S=31 -> 2.
      fb_if.divP = 6'd1;
      fb_if.divS = 5'd31;
      wait_wrap(100, w);
      wait_wrap(100, w);
      check_period("clamp", 2, 1, 2, 6);

      // Reset mid-period with shadowP=40.
      fb_if.divP = 6'd40;
      fb_if.divS = 5'd10;
      wait_wrap(100, w);
      wait_wrap(100, w);
      check_period("p40", 40, 20, 10, 90);
      for (int i = 0; i < 8; i++) step();
      check("cnt7_skip", fb_if.skip, 1'b1);
      check("cnt7_clkDiv", fb_if.clkDiv, 1'b1);
      check("cnt7_wrap", fb_if.wrapPulse, 1'b0);
      fb_if.divP = 6'd20;
      fb_if.divS = 5'd0;
      #1 enable = 1'b0;
      #1;
      check("async_skip", fb_if.skip, 1'b0);
      check("async_clkDiv", fb_if.clkDiv, 1'b0);
      check("async_wrap", fb_if.wrapPulse, 1'b0);
      for (int i = 0; i < 3; i++) step();
      enable = 1'b1;
      wait_wrap(100, w);
      check("post_rst_wrap_delay", w, 31);
      wait_wrap(100, w);
      check_period("post_rst", 20, 10, 0, 40);

      // Upset recovery with Peff=32.
      fb_if.divP = 6'd32;
      wait_wrap(100, w);
      wait_wrap(100, w);
      check_period("pre_upset", 32, 16, 0, 64);
      for (int i = 0; i < 5; i++) step();
      force dut.cnt_reg = 6'd50;
      upset_req++;
      #1 release dut.cnt_reg;
      wait_wrap(3, w);
      check("upset_wrap_delay", w, 1);
      wait_wrap(100, w);
      check("upset_recover_len", last_period, 31);
      wait_wrap(100, w);
      check_period("post_upset", 32, 16, 0, 64);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
